// File: rtl/sensor_cmd_decoder.sv
// Command layer between UART RX and TX: assembles {cmd, addr}, issues one sensor read and
// returns a two-byte response. Define SENSOR_CMD_DECODER_RGB_EN for the registered status LED.
module sensor_cmd_decoder #(
    parameter int unsigned NUM_SENSORS    = 32,
    parameter int unsigned BYTE_TIMEOUT   = 5_000_000,
    parameter int unsigned SENSOR_TIMEOUT = 50_000_000
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Tx_DV,
    output logic [7:0] o_Tx_Byte,
    input  logic       i_Tx_Active,
    input  logic       i_Tx_Done,
    output logic       o_Sensor_Req,
    output logic [7:0] o_Sensor_Addr,
    output logic [7:0] o_Sensor_Cmd,
    input  logic       i_Sensor_Valid,
    input  logic [7:0] i_Sensor_Data,
    output logic       o_Busy,
    output logic [2:0] o_Rgb
);

    localparam int unsigned ByteTw   = $clog2(BYTE_TIMEOUT + 1);
    localparam int unsigned SensorTw = $clog2(SENSOR_TIMEOUT + 1);
    // Expiry fires on the last counted cycle so the wait lasts exactly TIMEOUT clocks.
    localparam logic [ByteTw-1:0]   ByteLast   = ByteTw'(BYTE_TIMEOUT - 1);
    localparam logic [ByteTw-1:0]   ByteMax    = ByteTw'(BYTE_TIMEOUT);
    localparam logic [SensorTw-1:0] SensorLast = SensorTw'(SENSOR_TIMEOUT - 1);
    localparam logic [SensorTw-1:0] SensorMax  = SensorTw'(SENSOR_TIMEOUT);

    typedef enum logic [3:0] {
        StIdle, StGetAddr, StCheck, StSensorReq, StSensorWait,
        StSendB0, StWaitB0, StSendB1, StWaitB1
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [7:0]          addr_q, addr_d;
    logic [7:0]          resp0_q, resp0_d;
    logic [7:0]          resp1_q, resp1_d;
    logic [ByteTw-1:0]   byte_tmr_q, byte_tmr_d;
    logic [SensorTw-1:0] sensor_tmr_q, sensor_tmr_d;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_q      <= StIdle;
            cmd_q        <= '0;
            addr_q       <= '0;
            resp0_q      <= '0;
            resp1_q      <= '0;
            byte_tmr_q   <= '0;
            sensor_tmr_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            resp0_q      <= resp0_d;
            resp1_q      <= resp1_d;
            byte_tmr_q   <= byte_tmr_d;
            sensor_tmr_q <= sensor_tmr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        resp0_d      = resp0_q;
        resp1_d      = resp1_q;
        byte_tmr_d   = byte_tmr_q;
        sensor_tmr_d = sensor_tmr_q;
        unique case (state_q)
            StIdle: begin
                if (i_Rx_DV) begin
                    cmd_d      = i_Rx_Byte;
                    byte_tmr_d = '0;
                    state_d    = StGetAddr;
                end
            end
            StGetAddr: begin
                // A byte arriving on the expiry cycle still wins.
                if (i_Rx_DV) begin
                    addr_d  = i_Rx_Byte;
                    state_d = StCheck;
                end else if (byte_tmr_q == ByteLast) begin
                    state_d = StIdle;
                end else if (byte_tmr_q != ByteMax) begin
                    byte_tmr_d = byte_tmr_q + 1'b1;
                end
            end
            StCheck: begin
                if (cmd_q > 8'h07) begin
                    resp0_d = 8'hE0;
                    resp1_d = cmd_q;
                    state_d = StSendB0;
                end else if (32'(addr_q) >= NUM_SENSORS) begin
                    resp0_d = 8'hE1;
                    resp1_d = addr_q;
                    state_d = StSendB0;
                end else begin
                    state_d = StSensorReq;
                end
            end
            StSensorReq: begin
                sensor_tmr_d = '0;
                state_d      = StSensorWait;
            end
            StSensorWait: begin
                if (i_Sensor_Valid) begin
                    resp0_d = 8'h80 | cmd_q;
                    resp1_d = i_Sensor_Data;
                    state_d = StSendB0;
                end else if (sensor_tmr_q == SensorLast) begin
                    resp0_d = 8'hE2;
                    resp1_d = addr_q;
                    state_d = StSendB0;
                end else if (sensor_tmr_q != SensorMax) begin
                    sensor_tmr_d = sensor_tmr_q + 1'b1;
                end
            end
            StSendB0: if (!i_Tx_Active) state_d = StWaitB0;
            StWaitB0: if (i_Tx_Done)    state_d = StSendB1;
            StSendB1: if (!i_Tx_Active) state_d = StWaitB1;
            StWaitB1: if (i_Tx_Done)    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        o_Busy        = !(state_q == StIdle || state_q == StGetAddr);
        o_Sensor_Req  = (state_q == StSensorReq);
        o_Sensor_Addr = 8'h00;
        o_Sensor_Cmd  = 8'h00;
        if (state_q == StSensorReq || state_q == StSensorWait) begin
            o_Sensor_Addr = addr_q;
            o_Sensor_Cmd  = cmd_q;
        end
        o_Tx_DV   = (state_q == StSendB0 || state_q == StSendB1) && !i_Tx_Active;
        o_Tx_Byte = 8'h00;
        if (state_q == StSendB0 || state_q == StWaitB0) o_Tx_Byte = resp0_q;
        if (state_q == StSendB1 || state_q == StWaitB1) o_Tx_Byte = resp1_q;
    end

`ifdef SENSOR_CMD_DECODER_RGB_EN
    logic       err_q, err_d;
    logic [2:0] rgb_q, rgb_d;

    // Error responses are 0xE0..0xE2, data responses 0x80..0x87.
    always_comb begin
        err_d = err_q;
        if (state_d == StSendB0 && state_q != StSendB0) err_d = (resp0_d[7:5] == 3'b111);
        if (err_d)                                           rgb_d = 3'b100;
        else if (state_d == StIdle || state_d == StGetAddr) rgb_d = 3'b001;
        else                                                 rgb_d = 3'b010;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            err_q <= 1'b0;
            rgb_q <= 3'b000;
        end else begin
            err_q <= err_d;
            rgb_q <= rgb_d;
        end
    end

    assign o_Rgb = rgb_q;
`else
    assign o_Rgb = 3'b000;
`endif

endmodule

// File: tb/tb_sensor_cmd_decoder.sv
// Directed + randomized bench for sensor_cmd_decoder with a transmitter BFM and a
// response model computed from the request rules.
module tb_sensor_cmd_decoder;

    localparam int NumSensors = 32;
    localparam int ByteTo     = 20;
    localparam int SensorTo   = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_block = 1'b0;
    logic       svalid = 1'b0;
    logic [7:0] sdata = 8'h00;
    logic       tx_dv, sreq, busy, tx_active;
    logic [7:0] tx_byte, saddr, scmd;
    logic [2:0] rgb;

    logic       bfm_active = 1'b0;
    logic       bfm_done = 1'b0;
    logic       tx_seen = 1'b0;
    int         bfm_cnt = 0;
    int         cyc = 0;
    int         req_count = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] tx_q[$];

    assign tx_active = bfm_active | tx_block;

    always #5 clk = ~clk;

    sensor_cmd_decoder #(
        .NUM_SENSORS   (NumSensors),
        .BYTE_TIMEOUT  (ByteTo),
        .SENSOR_TIMEOUT(SensorTo)
    ) dut (
        .i_Clock       (clk),
        .i_Rst_n       (rst_n),
        .i_Rx_DV       (rx_dv),
        .i_Rx_Byte     (rx_byte),
        .o_Tx_DV       (tx_dv),
        .o_Tx_Byte     (tx_byte),
        .i_Tx_Active   (tx_active),
        .i_Tx_Done     (bfm_done),
        .o_Sensor_Req  (sreq),
        .o_Sensor_Addr (saddr),
        .o_Sensor_Cmd  (scmd),
        .i_Sensor_Valid(svalid),
        .i_Sensor_Data (sdata),
        .o_Busy        (busy),
        .o_Rgb         (rgb)
    );

    // Mid-cycle monitors: transmitted bytes and sensor requests.
    always @(negedge clk) begin
        tx_seen <= tx_dv;
        if (tx_dv) tx_q.push_back(tx_byte);
        if (sreq) req_count <= req_count + 1;
    end

    // Transmitter: busy for a random 1..4 cycles, then a one-cycle done.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_seen) begin
            bfm_active <= 1'b1;
            bfm_done   <= 1'b0;
            bfm_cnt    <= int'($urandom_range(1, 4));
        end else if (bfm_cnt > 1) begin
            bfm_cnt <= bfm_cnt - 1;
        end else if (bfm_cnt == 1) begin
            bfm_cnt  <= 0;
            bfm_done <= 1'b1;
        end else if (bfm_done) begin
            bfm_done   <= 1'b0;
            bfm_active <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv   = 1'b0;
    endtask

    function automatic logic [15:0] model_resp(input logic [7:0] cmd, input logic [7:0] addr,
                                               input bit answered, input logic [7:0] data);
        if (cmd > 8'h07) return {8'hE0, cmd};
        if (int'(addr) >= NumSensors) return {8'hE1, addr};
        if (!answered) return {8'hE2, addr};
        return {8'h80 | cmd, data};
    endfunction

    // delay: sensor answers delay+1 cycles after the request cycle; hold: cycles the
    // transmitter is held busy on the error path.
    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr, input int gap,
                           input int delay, input logic [7:0] data, input bit stray,
                           input int hold);
        logic [15:0] exp;
        logic [7:0]  b0, b1;
        bit          sensor_path, answered;
        int          base_req, t_req, n;
        sensor_path = (cmd <= 8'h07) && (int'(addr) < NumSensors);
        answered    = (delay + 1 <= SensorTo);
        exp         = model_resp(cmd, addr, answered, data);
        base_req    = req_count;
        tx_q.delete();
        if (hold > 0) tx_block = 1'b1;
        send_rx(cmd);
        idle(gap - 1);
        send_rx(addr);
        check("busy_in_check", busy, 1);
        tick();
        if (sensor_path) begin
            check("req_strobe", sreq, 1);
            check("req_addr", saddr, addr);
            check("req_cmd", scmd, cmd);
            t_req = cyc;
            tick();
            if (answered) begin
                for (int i = 0; i < delay; i++) begin
                    if (stray && i == 0) send_rx(8'h44);
                    else tick();
                end
                svalid = 1'b1;
                sdata  = data;
                tick();
                svalid = 1'b0;
                check("tx_dv_after_valid", tx_dv, 1);
            end else begin
                n = 0;
                if (stray) begin
                    send_rx(8'h44);
                    n++;
                end
                while (!tx_dv && n < SensorTo + 20) begin
                    tick();
                    n++;
                end
                check("timeout_latency", cyc - t_req, SensorTo + 1);
            end
        end else begin
            check("no_req", sreq, 0);
            if (hold > 0) begin
                check("tx_dv_held_off", tx_dv, 0);
                idle(hold);
                check("still_busy", busy, 1);
                tx_block = 1'b0;
                #1;
            end
            check("err_tx_dv", tx_dv, 1);
        end
        n = 0;
        while ((tx_q.size() < 2 || busy) && n < 300) begin
            tick();
            n++;
        end
        b0 = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
        b1 = (tx_q.size() > 1) ? tx_q[1] : 8'hxx;
        check("back_to_idle", busy, 0);
        check("tx_count", tx_q.size(), 2);
        check("resp_b0", b0, exp[15:8]);
        check("resp_b1", b1, exp[7:0]);
        check("req_count", req_count - base_req, sensor_path);
`ifdef SENSOR_CMD_DECODER_RGB_EN
        check("rgb", rgb, (exp[15:13] == 3'b111) ? 3'b100 : 3'b001);
`else
        check("rgb", rgb, 3'b000);
`endif
    endtask

    initial begin
        int n;
        logic [7:0] c, a;
        int d;

        // Reset state
        idle(2);
        check("rst_tx_dv", tx_dv, 0);
        check("rst_req", sreq, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_addr", saddr, 8'h00);
        check("rst_cmd", scmd, 8'h00);
        check("rst_rgb", rgb, 3'b000);
        rst_n = 1'b1;
        tick();
`ifdef SENSOR_CMD_DECODER_RGB_EN
        check("rgb_idle", rgb, 3'b001);
`else
        check("rgb_idle", rgb, 3'b000);
`endif

        // Valid read, sensor answers three cycles after the request
        run_txn(8'h03, 8'h05, 1, 2, 8'h2A, 1'b0, 0);
        // Bad command, transmitter busy for a while first
        run_txn(8'h09, 8'h01, 1, 0, 8'h00, 1'b0, 3);
        // Bad address, then last valid address
        run_txn(8'h01, 8'h20, 1, 0, 8'h00, 1'b0, 0);
        run_txn(8'h01, 8'h1F, 2, 0, 8'h11, 1'b0, 0);
        // Sensor timeout, then valid exactly on the expiry cycle
        run_txn(8'h02, 8'h07, 1, SensorTo + 5, 8'h00, 1'b1, 0);
        run_txn(8'h06, 8'h0A, 1, SensorTo - 1, 8'h5C, 1'b0, 0);
        // Stray byte during SENSOR_WAIT
        run_txn(8'h04, 8'h06, 1, 4, 8'h55, 1'b1, 0);

        // Lone byte dropped after the byte timeout; next pair is a fresh request
        send_rx(8'h02);
        idle(ByteTo + 1);
        check("drop_idle", busy, 0);
        run_txn(8'h03, 8'h05, 1, 1, 8'h77, 1'b0, 0);
        // Address arriving on the expiry cycle is accepted
        run_txn(8'h05, 8'h02, ByteTo, 0, 8'h99, 1'b0, 0);

        // Reset while in WAIT_B0
        tx_q.delete();
        send_rx(8'h03);
        send_rx(8'h05);
        tick();
        check("pre_rst_req", sreq, 1);
        tick();
        svalid = 1'b1;
        sdata  = 8'h66;
        tick();
        svalid = 1'b0;
        check("pre_rst_tx_dv", tx_dv, 1);
        tick();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_tx_byte", tx_byte, 8'h83);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_tx_dv", tx_dv, 0);
        check("midrst_req", sreq, 0);
        check("midrst_busy", busy, 0);
        check("midrst_tx_byte", tx_byte, 8'h00);
        check("midrst_addr", saddr, 8'h00);
        check("midrst_cmd", scmd, 8'h00);
        check("midrst_rgb", rgb, 3'b000);
        n = 0;
        while ((bfm_active || bfm_done) && n < 20) begin
            tick();
            n++;
        end
        run_txn(8'h00, 8'h00, 1, 1, 8'($urandom), 1'b0, 0);

        // Randomized requests
        for (int i = 0; i < 24; i++) begin
            c = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
            a = 8'($urandom_range(0, 40));
            d = ($urandom_range(0, 9) == 0) ? SensorTo + 3 : int'($urandom_range(0, 6));
            run_txn(c, a, int'($urandom_range(1, ByteTo)), d, 8'($urandom),
                    1'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
